pe_core_sequencer: RTL

Issue-side controller for the Winograd PE core. For one output tile group it walks every MESH_N input-channel group and every spatial tile, reading feature and weight buffers and driving the core's `in_valid`, `tofifo`, `fromfifo`, `bias_valid` and `poolop` beats. It then counts the core's `out_valid` pulses back to detect completion. It sits between the on-chip feature/weight buffers and the PE core, and is started by the layer controller.

---
 rtl/pe_core_sequencer_if.sv | 25 ++
 rtl/pe_core_sequencer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pe_core_sequencer_if.sv
// pe_core_sequencer_if: start/config, core-control and completion signals of the PE issue sequencer.
interface pe_core_sequencer_if #(
  parameter int CG_BIT    = 6,
  parameter int TILE_BIT  = 11,
  parameter int FADDR_BIT = 16,
  parameter int WADDR_BIT = 6
);
  logic                 start, abort, pool_cfg, pe_out_valid;
  logic [CG_BIT-1:0]    num_cg;
  logic [TILE_BIT-1:0]  num_tiles;
  logic                 buf_rd_en, in_valid, tofifo, fromfifo, bias_valid, poolop;
  logic                 result_wr_en, busy, done, cfg_err;
  logic [FADDR_BIT-1:0] feat_addr;
  logic [WADDR_BIT-1:0] wgt_addr;
  modport master (
    output start, abort, num_cg, num_tiles, pool_cfg, pe_out_valid,
    input  buf_rd_en, feat_addr, wgt_addr, in_valid, tofifo, fromfifo, bias_valid, poolop,
           result_wr_en, busy, done, cfg_err
  );
  modport slave (
    input  start, abort, num_cg, num_tiles, pool_cfg, pe_out_valid,
    output buf_rd_en, feat_addr, wgt_addr, in_valid, tofifo, fromfifo, bias_valid, poolop,
           result_wr_en, busy, done, cfg_err
  );
endinterface

// File: rtl/pe_core_sequencer.sv
// pe_core_sequencer: walks channel groups and tiles, issues buffer reads and PE core beats, counts results back.
module pe_core_sequencer #(
  parameter int          CG_BIT     = 6,
  parameter int          TILE_BIT   = 11,
  parameter int          FADDR_BIT  = 16,
  parameter int          WADDR_BIT  = 6,
  parameter int unsigned FIFO_DEPTH = 1024,
  parameter int          GAP_CYC    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  pe_core_sequencer_if.slave io
);
  localparam int RW = CG_BIT + TILE_BIT;
  localparam int GW = $clog2(GAP_CYC + 1) + 1;
  typedef enum logic [2:0] {IDLE, ISSUE, GAP, DRAIN, DONE} state_t;
  state_t               state_q, state_d;
  logic [CG_BIT-1:0]    g_q, g_d, gn_q, gn_d, rg_q, rg_d;
  logic [TILE_BIT-1:0]  t_q, t_d, tn_q, tn_d;
  logic [FADDR_BIT-1:0] f_q, f_d, fa_q, fa_d;
  logic [RW-1:0]        r_q, r_d, gt;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 pool_q, pool_d, rd_q, rd_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                 in_valid_q, in_valid_d, tofifo_q, tofifo_d, fromfifo_q, fromfifo_d;
  logic                 bias_q, bias_d, poolop_q, poolop_d, bad_cfg;
  always_comb begin
    bad_cfg = io.num_cg == '0 || io.num_tiles == '0 || 32'(io.num_tiles) > FIFO_DEPTH;
    gt      = RW'(gn_q) * RW'(tn_q);
    state_d = state_q;
    g_d     = g_q;
    t_d     = t_q;
    f_d     = f_q;
    r_d     = r_q + RW'(io.pe_out_valid && busy_q);
    gap_d   = gap_q;
    gn_d    = gn_q;
    tn_d    = tn_q;
    pool_d  = pool_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (io.start) begin
        gn_d   = io.num_cg;
        tn_d   = io.num_tiles;
        pool_d = io.pool_cfg;
        err_d  = bad_cfg;
        if (!bad_cfg) begin
          state_d = ISSUE;
          g_d     = '0;
          t_d     = '0;
          f_d     = '0;
          r_d     = '0;
        end
      end
      ISSUE: begin
        t_d = t_q + 1'b1;
        f_d = f_q + 1'b1;
        if (t_q == tn_q - 1'b1) begin
          t_d = '0;
          if (g_q == gn_q - 1'b1) state_d = DRAIN;
          else begin
            g_d     = g_q + 1'b1;
            gap_d   = '0;
            state_d = GAP_CYC == 0 ? ISSUE : GAP;
          end
        end
      end
      GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GW'(GAP_CYC - 1)) state_d = ISSUE;
      end
      DRAIN: if (r_d == gt) begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (!rst_n || io.abort) begin
      state_d = IDLE;
      g_d     = '0;
      t_d     = '0;
      f_d     = '0;
      r_d     = '0;
      gap_d   = '0;
      err_d   = 1'b0;
      done_d  = 1'b0;
    end
    rd_d   = state_d == ISSUE;
    fa_d   = rd_d ? f_d : '0;
    rg_d   = rd_d ? g_d : '0;
    busy_d = state_d inside {ISSUE, GAP, DRAIN};
    // the beat follows the read by one cycle so it lines up with buffer data; abort drops it
    in_valid_d = rd_q && rst_n && !io.abort;
    tofifo_d   = in_valid_d && rg_q < gn_q - 1'b1;
    fromfifo_d = in_valid_d && rg_q != '0;
    bias_d     = in_valid_d && rg_q == '0;
    poolop_d   = in_valid_d && pool_q;
  end
  always_ff @(posedge clk) begin
    state_q    <= state_d;
    g_q        <= g_d;
    t_q        <= t_d;
    f_q        <= f_d;
    r_q        <= r_d;
    gap_q      <= gap_d;
    gn_q       <= gn_d;
    tn_q       <= tn_d;
    pool_q     <= pool_d;
    rd_q       <= rd_d;
    fa_q       <= fa_d;
    rg_q       <= rg_d;
    busy_q     <= busy_d;
    done_q     <= done_d;
    err_q      <= err_d;
    in_valid_q <= in_valid_d;
    tofifo_q   <= tofifo_d;
    fromfifo_q <= fromfifo_d;
    bias_q     <= bias_d;
    poolop_q   <= poolop_d;
  end
  assign io.buf_rd_en    = rd_q;
  assign io.feat_addr    = fa_q;
  assign io.wgt_addr     = WADDR_BIT'(rg_q);
  assign io.in_valid     = in_valid_q;
  assign io.tofifo       = tofifo_q;
  assign io.fromfifo     = fromfifo_q;
  assign io.bias_valid   = bias_q;
  assign io.poolop       = poolop_q;
  assign io.busy         = busy_q;
  assign io.done         = done_q;
  assign io.cfg_err      = err_q;
  assign io.result_wr_en = io.pe_out_valid && busy_q && r_q >= RW'(gn_q - 1'b1) * RW'(tn_q);
endmodule
